// File: rtl/gate_check_pkg.sv
// gate_check_pkg: shared state type, vector sizing and common 2-input truth tables.
`default_nettype none

package gate_check_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int VEC_W    = 2;
   localparam int NUM_VECS = 4;

   // Truth tables are indexed by {a,b}; bit 0 is the {0,0} response.
   localparam logic [NUM_VECS-1:0] TT_NOR  = 4'b0001;
   localparam logic [NUM_VECS-1:0] TT_AND  = 4'b1000;
   localparam logic [NUM_VECS-1:0] TT_OR   = 4'b1110;
   localparam logic [NUM_VECS-1:0] TT_NAND = 4'b0111;

endpackage

`default_nettype wire

// File: rtl/gate_response_checker.sv
// gate_response_checker: exhaustive on-chip tester for a 2-input gate (rev 1.0).
// Optional first-failure capture enabled by defining GATE_CHECK_FIRST_FAIL_EN.
`default_nettype none

module gate_response_checker
   import gate_check_pkg::*;
#(
   parameter logic [NUM_VECS-1:0] TRUTH_TABLE   = TT_NOR,
   parameter int unsigned         SETTLE_CYCLES = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             y,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [2:0]       err_count
`ifdef GATE_CHECK_FIRST_FAIL_EN
   ,
   output logic             first_fail_vld,
   output logic [VEC_W-1:0] first_fail_vec
`endif
);

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECS - 1);

   state_t           state;
   logic [VEC_W-1:0] vec_idx;
   logic [3:0]       settle_cnt;
   logic             mismatch;
   logic [2:0]       err_next;

   assign mismatch = (y != TRUTH_TABLE[{a, b}]);
   assign err_next = err_count + {2'b00, mismatch};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         vec_idx    <= '0;
         settle_cnt <= '0;
         a          <= 1'b0;
         b          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
`ifdef GATE_CHECK_FIRST_FAIL_EN
         first_fail_vld <= 1'b0;
         first_fail_vec <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= SETTLE;
                  vec_idx    <= '0;
                  settle_cnt <= '0;
                  a          <= 1'b0;
                  b          <= 1'b0;
                  err_count  <= '0;
                  done       <= 1'b0;
                  busy       <= 1'b1;
`ifdef GATE_CHECK_FIRST_FAIL_EN
                  first_fail_vld <= 1'b0;
                  first_fail_vec <= '0;
`endif
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 4'd1;
               if (settle_cnt == SETTLE_LAST) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               err_count <= err_next;
`ifdef GATE_CHECK_FIRST_FAIL_EN
               if (mismatch && !first_fail_vld) begin
                  first_fail_vld <= 1'b1;
                  first_fail_vec <= {a, b};
               end
`endif
               // pass must include this final compare, hence err_next.
               if (vec_idx == LAST_VEC) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == 3'd0);
               end else begin
                  vec_idx    <= vec_idx + 2'd1;
                  {a, b}     <= vec_idx + 2'd1;
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: timeline model of the run plus directed literal checks.
`default_nettype none

module tb_gate_response_checker;
   import gate_check_pkg::*;

   localparam int S0 = 5;
   localparam int S1 = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start0 = 1'b0, start1 = 1'b0;
   logic y0, y1;
   logic a0, b0, busy0, done0, pass0;
   logic a1, b1, busy1, done1, pass1;
   logic [2:0] err0, err1;
`ifdef GATE_CHECK_FIRST_FAIL_EN
   logic ffv0, ffv1;
   logic [1:0] ffvec0, ffvec1;
`endif

   int checks = 0;
   int failures = 0;

   // Gate under test: selectable truth table and 0/1/2-cycle output delay.
   logic [3:0] gtt [2] = '{TT_NOR, TT_NOR};
   int         gdly[2] = '{0, 0};
   logic       p1  [2] = '{1'b0, 1'b0};
   logic       p2  [2] = '{1'b0, 1'b0};
   logic       raw0, raw1;

   always #5 clk = ~clk;

   assign raw0 = gtt[0][{a0, b0}];
   assign raw1 = gtt[1][{a1, b1}];
   always @(posedge clk) begin
      p1[0] <= raw0; p2[0] <= p1[0];
      p1[1] <= raw1; p2[1] <= p1[1];
   end
   assign y0 = (gdly[0] == 0) ? raw0 : (gdly[0] == 1) ? p1[0] : p2[0];
   assign y1 = (gdly[1] == 0) ? raw1 : (gdly[1] == 1) ? p1[1] : p2[1];

   gate_response_checker #(.TRUTH_TABLE(TT_NOR), .SETTLE_CYCLES(S0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .y(y0), .a(a0), .b(b0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef GATE_CHECK_FIRST_FAIL_EN
      , .first_fail_vld(ffv0), .first_fail_vec(ffvec0)
`endif
   );

   gate_response_checker #(.TRUTH_TABLE(TT_NOR), .SETTLE_CYCLES(S1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .y(y1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef GATE_CHECK_FIRST_FAIL_EN
      , .first_fail_vld(ffv1), .first_fail_vec(ffvec1)
`endif
   );

   // Model: a run is a count of edges since the accepting edge; every
   // (S+1)-th edge is a sample of vector n/(S+1)-1.
   int n_m[2], err_m[2], vec_m[2], ffvec_m[2];
   bit act_m[2], done_m[2], pass_m[2], ffv_m[2];

   task automatic model_reset(input int k);
      n_m[k] = 0; err_m[k] = 0; vec_m[k] = 0; ffvec_m[k] = 0;
      act_m[k] = 0; done_m[k] = 0; pass_m[k] = 0; ffv_m[k] = 0;
   endtask

   task automatic model_step(input int k, input int s, input bit st, input bit yv);
      int v;
      if (!act_m[k] && st) begin
         act_m[k] = 1; n_m[k] = 0; err_m[k] = 0; vec_m[k] = 0;
         done_m[k] = 0; ffv_m[k] = 0; ffvec_m[k] = 0;
      end else if (act_m[k]) begin
         n_m[k]++;
         if (n_m[k] % (s + 1) == 0) begin
            v = n_m[k] / (s + 1) - 1;
            if (yv != TT_NOR[v]) begin
               err_m[k]++;
               if (!ffv_m[k]) begin ffv_m[k] = 1; ffvec_m[k] = v; end
            end
            if (v == 3) begin
               act_m[k] = 0; done_m[k] = 1; pass_m[k] = (err_m[k] == 0);
            end
         end
         if (act_m[k]) vec_m[k] = n_m[k] / (s + 1);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0, S0, start0, y0);
         model_step(1, S1, start1, y1);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp(input int k, input logic av, input logic bv, input logic busyv,
                      input logic donev, input logic passv, input logic [2:0] errv);
      chk($sformatf("dut%0d_a", k), av, (vec_m[k] >> 1) & 1);
      chk($sformatf("dut%0d_b", k), bv, vec_m[k] & 1);
      chk($sformatf("dut%0d_busy", k), busyv, act_m[k]);
      chk($sformatf("dut%0d_done", k), donev, done_m[k]);
      chk($sformatf("dut%0d_err", k), errv, err_m[k]);
      if (done_m[k]) chk($sformatf("dut%0d_pass", k), passv, pass_m[k]);
   endtask

   always @(negedge clk) begin
      cmp(0, a0, b0, busy0, done0, pass0, err0);
      cmp(1, a1, b1, busy1, done1, pass1, err1);
`ifdef GATE_CHECK_FIRST_FAIL_EN
      chk("dut0_ffv", ffv0, ffv_m[0]);
      chk("dut1_ffv", ffv1, ffv_m[1]);
      if (ffv_m[0]) chk("dut0_ffvec", ffvec0, ffvec_m[0]);
      if (ffv_m[1]) chk("dut1_ffvec", ffvec1, ffvec_m[1]);
`endif
   end

   task automatic set_start(input int k, input logic v);
      if (k == 0) start0 = v; else start1 = v;
   endtask

   // Pulse start, then count edges from the accepting edge until done.
   task automatic run(input int k, input int repulse, output int edges);
      @(posedge clk); #2; set_start(k, 1'b1);
      @(posedge clk); #2; set_start(k, 1'b0);
      chk("accept_busy", (k == 0) ? busy0 : busy1, 1);
      chk("accept_done", (k == 0) ? done0 : done1, 0);
      chk("accept_err", (k == 0) ? err0 : err1, 0);
      edges = 0;
      while (!((k == 0) ? done0 : done1) && edges < 200) begin
         @(posedge clk); #2;
         edges++;
         set_start(k, (edges == repulse) ? 1'b1 : 1'b0);
      end
      set_start(k, 1'b0);
   endtask

   initial begin
      int e;
      int rst_hold;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      chk("rst_a", a0, 0); chk("rst_b", b0, 0); chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0); chk("rst_pass", pass0, 0); chk("rst_err", err0, 0);

      // Correct NOR gate.
      gtt[0] = TT_NOR; gdly[0] = 0;
      run(0, -1, e);
      chk("nor_edges", e, 24); chk("nor_err", err0, 0); chk("nor_pass", pass0, 1);

      // NAND against the NOR table: 01 and 10 mismatch.
      gtt[0] = TT_NAND;
      run(0, -1, e);
      chk("nand_err", err0, 2); chk("nand_pass", pass0, 0);
`ifdef GATE_CHECK_FIRST_FAIL_EN
      chk("nand_ffv", ffv0, 1); chk("nand_ffvec", ffvec0, 2'b01);
`endif

      // y stuck at 1; result held until the next start.
      gtt[0] = 4'b1111;
      run(0, -1, e);
      chk("stuck_err", err0, 3); chk("stuck_pass", pass0, 0);
      repeat (10) @(posedge clk);
      #2 chk("stuck_hold_done", done0, 1); chk("stuck_hold_err", err0, 3);

      // Re-run from DONE with a start re-pulse while busy.
      gtt[0] = TT_NOR;
      run(0, 10, e);
      chk("repulse_edges", e, 24); chk("repulse_err", err0, 0); chk("repulse_pass", pass0, 1);

      // Asynchronous reset in the middle of vector 10.
      @(posedge clk); #2 start0 = 1'b1;
      @(posedge clk); #2 start0 = 1'b0;
      repeat (13) @(posedge clk);
      #2 chk("mid_a", a0, 1); chk("mid_b", b0, 0); chk("mid_busy", busy0, 1);
      #1 rst_n = 1'b0;
      #1 chk("arst_a", a0, 0); chk("arst_b", b0, 0); chk("arst_busy", busy0, 0);
      chk("arst_done", done0, 0); chk("arst_pass", pass0, 0); chk("arst_err", err0, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      run(0, -1, e);
      chk("post_rst_edges", e, 24); chk("post_rst_pass", pass0, 1);

      // One-cycle settle: 1-cycle-delayed gate passes, 2-cycle-delayed gate fails.
      gtt[1] = TT_NOR; gdly[1] = 1;
      run(1, -1, e);
      chk("s1_d1_edges", e, 8); chk("s1_d1_pass", pass1, 1); chk("s1_d1_err", err1, 0);
      gdly[1] = 2;
      run(1, -1, e);
      chk("s1_d2_edges", e, 8); chk("s1_d2_pass", pass1, 0); chk("s1_d2_err", err1, 2);

      // Random starts, gate behaviours and resets against the model.
      rst_hold = 0;
      for (int c = 0; c < 2500; c++) begin
         @(posedge clk); #2;
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst_n = 1'b1;
         end
         start0 = ($urandom % 16 == 0);
         start1 = ($urandom % 8 == 0);
         if (c % 128 == 0) begin
            for (int j = 0; j < 2; j++) begin
               gtt[j]  = ($urandom % 2 == 0) ? TT_NOR : 4'($urandom);
               gdly[j] = $urandom_range(0, 2);
            end
         end
         if (rst_hold == 0 && $urandom % 300 == 0) begin
            #1 rst_n = 1'b0;
            rst_hold = $urandom_range(1, 2);
         end
      end
      @(posedge clk); #2;
      start0 = 1'b0; start1 = 1'b0; rst_n = 1'b1;
      repeat (60) @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
